lsu_dbus_master: RTL

- Load/store request sequencer between the LSU pipeline stage and the data-bus bridge.
- Accepts one memory op at a time, encodes it as a dbus request (addr, wdata, wen, wstrb), and waits for the bus response on loads.
- Extracts the addressed byte/half/word and sign- or zero-extends it.
- Returns one result per op, flagging misaligned accesses and bus response timeouts.

---
 rtl/lsu_dbus_master_if.sv | 55 +++++
 rtl/lsu_dbus_master.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_dbus_master_if.sv
// LSU op / result / dbus request-response signal bundle between the LSU stage, this block and the bus bridge.
// Latency: none, wires only.
// Backpressure: carried by the valid/ready pairs inside; the bundle itself adds none.
interface lsu_dbus_master_if;
  // LSU op request
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_bits_addr;
  logic [31:0] io_in_bits_wdata;
  logic        io_in_bits_wen;
  logic [2:0]  io_in_bits_func3;
  // Result back to the LSU
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_bits_rdata;
  logic        io_out_bits_misaligned;
  logic        io_out_bits_err;
  // dbus request
  logic        io_bus_req_valid;
  logic        io_bus_req_ready;
  logic [31:0] io_bus_req_bits_addr;
  logic [31:0] io_bus_req_bits_wdata;
  logic        io_bus_req_bits_wen;
  logic [3:0]  io_bus_req_bits_wstrb;
  // dbus response
  logic        io_bus_resp_valid;
  logic        io_bus_resp_ready;
  logic [31:0] io_bus_resp_bits;

  // Sequencer side
  modport master (
    input  io_in_valid, io_in_bits_addr, io_in_bits_wdata, io_in_bits_wen, io_in_bits_func3,
    output io_in_ready,
    output io_out_valid, io_out_bits_rdata, io_out_bits_misaligned, io_out_bits_err,
    input  io_out_ready,
    output io_bus_req_valid, io_bus_req_bits_addr, io_bus_req_bits_wdata,
    output io_bus_req_bits_wen, io_bus_req_bits_wstrb,
    input  io_bus_req_ready,
    input  io_bus_resp_valid, io_bus_resp_bits,
    output io_bus_resp_ready
  );

  // Environment side (LSU stage plus bus bridge)
  modport slave (
    output io_in_valid, io_in_bits_addr, io_in_bits_wdata, io_in_bits_wen, io_in_bits_func3,
    input  io_in_ready,
    input  io_out_valid, io_out_bits_rdata, io_out_bits_misaligned, io_out_bits_err,
    output io_out_ready,
    input  io_bus_req_valid, io_bus_req_bits_addr, io_bus_req_bits_wdata,
    input  io_bus_req_bits_wen, io_bus_req_bits_wstrb,
    output io_bus_req_ready,
    output io_bus_resp_valid, io_bus_resp_bits,
    input  io_bus_resp_ready
  );
endinterface

// File: rtl/lsu_dbus_master.sv
// One-at-a-time load/store sequencer: encodes ops onto the dbus and sign/zero-extends load data.
// Latency: result valid 2 cycles after op accept on a zero-wait bus; a misaligned op finishes 1 cycle after accept.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready; loads time out after TIMEOUT cycles in WAIT.
module lsu_dbus_master #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  lsu_dbus_master_if.master io
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam bit               WD_EN  = (TIMEOUT != 0);

  // Access size encoding: 0 byte, 1 half, 2 word. Unsupported func3 codes fall into word.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = 2'd0;
      2'b01:   size_of = 2'd1;
      default: size_of = 2'd2;
    endcase
  endfunction

  // Alignment test against the access size.
  function automatic logic misaligned_of(input logic [2:0] f3, input logic [1:0] a);
    case (size_of(f3))
      2'd0:    misaligned_of = 1'b0;
      2'd1:    misaligned_of = a[0];
      default: misaligned_of = (a != 2'b00);
    endcase
  endfunction

  // Pick the addressed lane out of the bus word and extend it; func3[2] selects zero-extension.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] a,
                                          input logic [2:0] f3);
    logic [31:0] sh;
    logic        sgn;
    sh  = word >> {a, 3'b000};
    sgn = ~f3[2];
    case (size_of(f3))
      2'd0:    extract = {{24{sh[7] & sgn}}, sh[7:0]};
      2'd1:    extract = {{16{sh[15] & sgn}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [2:0]        func3_q, func3_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misal_q, misal_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0]       in_wdata_enc;
  logic [3:0]        in_wstrb_enc;
  logic              in_misal;
  logic [CNT_W-1:0]  cnt_inc;

  // Encode the incoming op into replicated store lanes and byte strobes; loads carry no data and no strobes.
  always_comb begin
    in_wdata_enc = 32'd0;
    in_wstrb_enc = 4'b0000;
    in_misal     = misaligned_of(io.io_in_bits_func3, io.io_in_bits_addr[1:0]);
    if (io.io_in_bits_wen) begin
      case (size_of(io.io_in_bits_func3))
        2'd0: begin
          in_wdata_enc = {4{io.io_in_bits_wdata[7:0]}};
          in_wstrb_enc = 4'b0001 << io.io_in_bits_addr[1:0];
        end
        2'd1: begin
          in_wdata_enc = {2{io.io_in_bits_wdata[15:0]}};
          in_wstrb_enc = 4'b0011 << io.io_in_bits_addr[1:0];
        end
        default: begin
          in_wdata_enc = io.io_in_bits_wdata;
          in_wstrb_enc = 4'b1111;
        end
      endcase
    end
  end

  // Next-state and next-field logic for the IDLE/REQ/WAIT/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    func3_d     = func3_q;
    req_wdata_d = req_wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    misal_d     = misal_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (io.io_in_valid) begin
          addr_d      = io.io_in_bits_addr;
          wen_d       = io.io_in_bits_wen;
          func3_d     = io.io_in_bits_func3;
          req_wdata_d = in_wdata_enc;
          wstrb_d     = in_wstrb_enc;
          rdata_d     = 32'd0;
          misal_d     = in_misal;
          err_d       = 1'b0;
          cnt_d       = '0;
          // Misaligned ops never touch the bus.
          state_d     = in_misal ? DONE : REQ;
        end
      end
      REQ: begin
        if (io.io_bus_req_ready) begin
          if (wen_q) begin
            state_d = DONE;
          end else if (io.io_bus_resp_valid) begin
            // Zero-wait bus: response arrives with the request handshake.
            rdata_d = extract(io.io_bus_resp_bits, addr_q[1:0], func3_q);
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (io.io_bus_resp_valid) begin
          // A response in the watchdog's last cycle still wins over the timeout.
          rdata_d = extract(io.io_bus_resp_bits, addr_q[1:0], func3_q);
          state_d = DONE;
        end else if (WD_EN && (cnt_inc == TO_CNT)) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.io_out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched op fields; synchronous reset clears everything including the watchdog.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      wen_q       <= 1'b0;
      func3_q     <= 3'd0;
      req_wdata_q <= 32'd0;
      wstrb_q     <= 4'b0000;
      rdata_q     <= 32'd0;
      misal_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      func3_q     <= func3_d;
      req_wdata_q <= req_wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      misal_q     <= misal_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs come straight from flops, except resp_ready which must see req_ready for the zero-wait case.
  always_comb begin
    io.io_in_ready            = (state_q == IDLE);
    io.io_out_valid           = (state_q == DONE);
    io.io_out_bits_rdata      = rdata_q;
    io.io_out_bits_misaligned = misal_q;
    io.io_out_bits_err        = err_q;
    io.io_bus_req_valid       = (state_q == REQ);
    io.io_bus_req_bits_addr   = {addr_q[31:2], 2'b00};
    io.io_bus_req_bits_wdata  = req_wdata_q;
    io.io_bus_req_bits_wen    = wen_q;
    io.io_bus_req_bits_wstrb  = wstrb_q;
    io.io_bus_resp_ready      = (state_q == WAIT) |
                                ((state_q == REQ) & ~wen_q & io.io_bus_req_ready);
  end

endmodule
